// File: rtl/tt_toggle_pkg.sv
// Shared encodings and default widths for the multi-channel toggle divider.
package tt_toggle_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DIV_W  = 8;
  localparam int DEF_CH_W   = 2;

  // Channel waveform mode as written through the config port
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_TOGGLE  = 2'd1,
    MODE_PULSE   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  // Per-channel sequencing state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/tt_toggle_div_ch.sv
// One divider channel: wrap counter, channel state, registered out/tick.
// A load restarts the channel from zero; a sync pulse re-phases a running
// channel. A load always wins over a sync in the same cycle.
module tt_toggle_div_ch
  import tt_toggle_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  mode_e            i_mode,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_sync,
  output logic             o_out,
  output logic             o_tick
);

  ch_state_e        r_state, w_state_nxt;
  mode_e            r_mode, w_mode_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_out, w_out_nxt;
  logic             r_tick, w_tick_nxt;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_OFF;
      r_div   <= '0;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Next-state, counter and waveform decode
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = 1'b0;
    w_tick_nxt  = 1'b0;
    if (i_load) begin
      // abrupt restart: output forced low, no tick on the load edge
      w_mode_nxt  = i_mode;
      w_div_nxt   = i_div;
      w_cnt_nxt   = '0;
      w_state_nxt = (i_mode == MODE_OFF) ? ST_IDLE : ST_RUN;
    end else if (i_sync && (r_state == ST_RUN)) begin
      w_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_cnt == r_div) begin
            w_cnt_nxt  = '0;
            w_tick_nxt = 1'b1;
            case (r_mode)
              MODE_TOGGLE:  w_out_nxt = ~r_out;
              MODE_PULSE:   w_out_nxt = 1'b1;
              MODE_ONESHOT: begin
                w_out_nxt   = 1'b1;
                w_state_nxt = ST_DONE;
              end
              default:      w_out_nxt = 1'b0;
            endcase
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
            w_out_nxt = (r_mode == MODE_TOGGLE) ? r_out : 1'b0;
          end
        end
        ST_DONE: begin
          w_cnt_nxt = r_cnt;
        end
        ST_IDLE: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_out  = r_out;
  assign o_tick = r_tick;

endmodule

// File: rtl/tt_toggle_divider.sv
// Multi-channel programmable square-wave / pulse generator.
// Config writes use a valid/ready port limited to one write per two cycles.
// Optional macro TOGGLE_SYNC_EN adds sync_in, which re-phases all running
// channels at once.
module tt_toggle_divider
  import tt_toggle_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef TOGGLE_SYNC_EN
  input  logic              sync_in,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] ch_out,
  output logic [NUM_CH-1:0] ch_tick,
  output logic              cfg_err
);

  logic              r_ready;
  logic              r_err;
  logic              w_accept;
  logic              w_in_range;
  logic              w_sync;
  logic [NUM_CH-1:0] w_load;

  assign w_accept   = cfg_valid & r_ready;
  // one extra bit so that NUM_CH == 2**CH_W is representable
  assign w_in_range = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));

`ifdef TOGGLE_SYNC_EN
  assign w_sync = sync_in;
`else
  assign w_sync = 1'b0;
`endif

  // Handshake pacing and sticky out-of-range flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_ready <= ~w_accept;
      r_err   <= r_err | (w_accept & ~w_in_range);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_load[g] = w_accept & w_in_range & (cfg_ch == CH_W'(g));

    tt_toggle_div_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load[g]),
      .i_mode (mode_e'(cfg_mode)),
      .i_div  (cfg_div),
      .i_sync (w_sync),
      .o_out  (ch_out[g]),
      .o_tick (ch_tick[g])
    );
  end

  assign cfg_ready = r_ready;
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_tt_toggle_divider.sv
// Scoreboard bench for tt_toggle_divider. The reference model derives each
// channel's waveform from the number of edges since its last (re)start.
module tb_tt_toggle_divider;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [1:0]        cfg_mode = 2'd0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              sync_in = 1'b0;
  logic              cfg_ready;
  logic              cfg_err;
  logic [NUM_CH-1:0] ch_out;
  logic [NUM_CH-1:0] ch_tick;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [NUM_CH-1:0] out;
    logic [NUM_CH-1:0] tick;
    logic              ready;
    logic              err;
  } exp_t;

  exp_t sb[$];

  int m_mode[NUM_CH];
  int m_div[NUM_CH];
  int m_anchor[NUM_CH];
  int m_edge;
  bit m_ready;
  bit m_err;

  tt_toggle_divider #(
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W),
    .CH_W   (CH_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef TOGGLE_SYNC_EN
    .sync_in   (sync_in),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .ch_out    (ch_out),
    .ch_tick   (ch_tick),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c]   = 0;
      m_div[c]    = 0;
      m_anchor[c] = 0;
    end
    m_edge  = 0;
    m_ready = 1'b1;
    m_err   = 1'b0;
  endfunction

  // Expected outputs after the coming edge, given the inputs presented to it.
  function automatic exp_t model_step(input bit v, input int ch, input int mode,
                                      input int d, input bit s);
    exp_t e;
    bit   acc;
    int   t;
    e = '0;
    m_edge++;
    acc = v && m_ready;
    for (int c = 0; c < NUM_CH; c++) begin
      if (acc && ch == c) begin
        m_mode[c]   = mode;
        m_div[c]    = d;
        m_anchor[c] = m_edge;
      end else if (m_mode[c] != 0) begin
        t = m_edge - m_anchor[c];
        // a one-shot is still running while its single wrap has not happened
        if (s && (m_mode[c] != 3 || t <= m_div[c] + 1)) begin
          m_anchor[c] = m_edge;
        end else begin
          case (m_mode[c])
            1: begin
              e.tick[c] = (t % (m_div[c] + 1)) == 0;
              e.out[c]  = ((t / (m_div[c] + 1)) % 2) == 1;
            end
            2: begin
              e.tick[c] = (t % (m_div[c] + 1)) == 0;
              e.out[c]  = e.tick[c];
            end
            default: begin
              e.tick[c] = (t == m_div[c] + 1);
              e.out[c]  = e.tick[c];
            end
          endcase
        end
      end
    end
    if (acc && ch >= NUM_CH) m_err = 1'b1;
    m_ready = !acc;
    e.ready = m_ready;
    e.err   = m_err;
    return e;
  endfunction

  // Drive one cycle of inputs (called just after a rising edge).
  task automatic cycle(input bit v, input int ch, input int mode, input int d, input bit s);
`ifndef TOGGLE_SYNC_EN
    s = 1'b0;
`endif
    cfg_valid = v;
    cfg_ch    = ch[CH_W-1:0];
    cfg_mode  = mode[1:0];
    cfg_div   = d[DIV_W-1:0];
    sync_in   = s;
    sb.push_back(model_step(v, ch, mode, d, s));
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic write(input int ch, input int mode, input int d);
    cycle(1'b1, ch, mode, d, 1'b0);
    cycle(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic random_phase(input int n, input bit allow_bad);
    int ch;
    int d;
    bit v;
    bit s;
    for (int i = 0; i < n; i++) begin
      ch = allow_bad ? int'($urandom_range(7, 0)) : int'($urandom_range(3, 0));
      d  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(255, 0)) : int'($urandom_range(6, 0));
      v  = ($urandom_range(9, 0) < 2);
      s  = ($urandom_range(39, 0) == 0);
      cycle(v, ch, int'($urandom_range(3, 0)), d, s);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic async_reset();
    #1;
    rst = 1'b1;
    cfg_valid = 1'b0;
    sync_in = 1'b0;
    sb.delete();
    #1;
    check("rst_async_out", ch_out, 0);
    check("rst_async_tick", ch_tick, 0);
    check("rst_async_ready", cfg_ready, 1);
    check("rst_async_err", cfg_err, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare each edge's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ch_out", ch_out, e.out);
        check("ch_tick", ch_tick, e.tick);
        check("cfg_ready", cfg_ready, e.ready);
        check("cfg_err", cfg_err, e.err);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // Stimulus sequence
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("reset_out", ch_out, 0);
    check("reset_tick", ch_tick, 0);
    check("reset_ready", cfg_ready, 1);
    check("reset_err", cfg_err, 0);
    rst = 1'b0;

    // toggle D=3: period 8, first rise 4 edges after accept
    write(0, 1, 3);
    idle(20);

    // pulse ch1 D=0, then ch2 D=4 offered during the ready gap
    cycle(1'b1, 1, 2, 0, 1'b0);
    cycle(1'b1, 2, 2, 4, 1'b0);
    cycle(1'b1, 2, 2, 4, 1'b0);
    idle(20);

    // one-shot D=2, long silence, then re-arm
    write(3, 3, 2);
    idle(55);
    write(3, 3, 2);
    idle(6);

    random_phase(400, 1'b0);

    // mid-waveform restart of ch0 to OFF while its output is high
    write(0, 1, 3);
    idle(3);
    write(0, 0, 7);
    idle(10);

    // out-of-range channel: sticky error, no channel change
    write(5, 1, 0);
    idle(5);
    random_phase(200, 1'b1);

    async_reset();
    idle(5);
    random_phase(300, 1'b1);

`ifdef TOGGLE_SYNC_EN
    async_reset();
    write(0, 1, 1);
    idle(1);
    write(1, 1, 2);
    idle(5);
    cycle(1'b0, 0, 0, 0, 1'b1);
    idle(10);
`endif

    idle(2);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_toggle_divider.md
Name: tt_toggle_divider

Overview:
- Multi-channel programmable square-wave / pulse generator for the Tiny Tapeout FPGA template.
- Each channel is an independent divider with its own mode, configured through a valid/ready write port.
- Drives observable waveforms onto the uo_out / uio_out pads for board bring-up and as a timing source for later blocks.
- Generalises the single fixed clk/2 toggle into N channels with programmable ratio and mode.

Parameters:
- NUM_CH, 4: number of channels, 1..8.
- DIV_W, 8: width of the per-channel divide register.
- CH_W, 2: width of the channel select. Must be ≥ ceil(log2(NUM_CH)) and ≥ 1.

Ports:
- clk  in  1: single clock.
- rst  in  1: asynchronous, active-high reset.
- cfg_valid  in  1: configuration write request.
- cfg_ready  out  1: block can accept a write.
- cfg_ch  in  CH_W: target channel.
- cfg_mode  in  2: 0=OFF, 1=TOGGLE, 2=PULSE, 3=ONESHOT.
- cfg_div  in  DIV_W: divide value D.
- ch_out  out  NUM_CH: per-channel waveform, registered.
- ch_tick  out  NUM_CH: one-cycle pulse on each counter wrap, registered.
- cfg_err  out  1: sticky flag, set by a write with cfg_ch ≥ NUM_CH.

Behaviour:
- Reset (async assert, sync release):
  - ch_out=0, ch_tick=0, cfg_err=0, cfg_ready=1.
  - All channels: mode=OFF, D=0, counter=0, state IDLE.
- Handshake:
  - A write is accepted at rising edge E0 when cfg_valid & cfg_ready.
  - cfg_ready is 0 for the one cycle after E0 and returns to 1 after E1. Maximum rate is one write per 2 cycles.
  - cfg_* is ignored while cfg_ready=0.
- On accept to channel c:
  - mode/D load at E0.
  - counter, ch_out[c] and ch_tick[c] clear to 0 at E0.
  - State becomes RUN, or IDLE if mode=OFF.
  - This applies even mid-waveform: an abrupt restart, output forced low, no tick.
- Out-of-range cfg_ch: handshake completes normally, no channel changes, cfg_err←1. cfg_err clears only on rst.
- Counter (RUN state):
  - Increments each cycle.
  - At count==D, the next edge wraps it to 0 and ch_tick pulses for 1 cycle.
  - First tick is registered at edge E(D+1) after accept; period is D+1 cycles.
  - Unsigned arithmetic, no saturation.
- Per-mode output:
  - OFF: counter held at 0, ch_out=0, ch_tick=0.
  - TOGGLE: ch_out inverts on every wrap. Period 2(D+1). D=0 gives clk/2.
  - PULSE: ch_out equals ch_tick. D=0 gives ch_out constantly 1 from E1 onward.
  - ONESHOT: on the first wrap, ch_out=1 and ch_tick=1 for one cycle, then state DONE: counter held, ch_out=0. Re-arming requires a new write.
- Channel states: IDLE → RUN (on write with mode≠OFF). RUN → DONE (ONESHOT wrap only). Any state → IDLE or RUN on a new write.
- Channels never interact except through the shared config port.

Optional Feature:
- Macro: TOGGLE_SYNC_EN.
- When defined:
  - Adds input port sync_in (1 bit).
  - A cycle with sync_in=1 clears counter, ch_out and ch_tick of every RUN channel at the next edge. Phase-aligns all channels.
  - DONE channels are unaffected.
  - If a write is accepted in the same cycle, the addressed channel takes the write and the others take the sync.
- When undefined: no sync_in port; channels free-run from their own write.

Decomposition:
- Package tt_toggle_pkg:
  - mode encodings MODE_OFF/TOGGLE/PULSE/ONESHOT;
  - channel state encodings IDLE/RUN/DONE;
  - default widths.
- Sub-module tt_toggle_div_ch: one channel (counter, state, out/tick regs, load/sync inputs), instantiated NUM_CH times by generate.
- Top level: config handshake, channel decode, cfg_err.

Test Plan:
- Reset, then write ch0 TOGGLE D=3 → ch_out[0] period 8 cycles; first rise 4 cycles after accept; ch_tick[0] every 4 cycles; other channels stay 0.
- Write ch1 PULSE D=0 and ch2 PULSE D=4 back-to-back (ready gap honoured):
  - ch_out[1] is 1 continuously from one cycle after accept;
  - ch_out[2] is high 1 cycle in every 5;
  - cfg_ready pattern is 1,0,1.
- Write ch3 ONESHOT D=2 → a single 1-cycle pulse on ch_out[3] and ch_tick[3] at edge E3, then silence for more than 50 cycles. A rewrite re-fires it.
- Mid-waveform rewrite of ch0 (TOGGLE D=3, while out=1) to OFF → ch_out[0]=0 at E0 and held. Write cfg_ch=5 with NUM_CH=4 → cfg_err=1, all channels unchanged.
- Assert rst asynchronously mid-cycle while channels run → all outputs 0 immediately (before the next edge); cfg_ready=1; after release, channels are OFF.
- With TOGGLE_SYNC_EN: ch0 TOGGLE D=1 and ch1 TOGGLE D=2 out of phase, pulse sync_in → both clear in the same edge and rise together 2 and 3 cycles later respectively.
